// File: rtl/event_counter_bank.sv
// Multi-channel event counter bank: per-channel runtime terminal, step K with
// saturation at the terminal, level or rising-edge qualification, wrap or one-shot.
module event_counter_bank #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8,
   parameter int MAX      = 4,
   parameter int K        = 1,
   parameter int DELAY    = 0,
   parameter int EDGE     = 0,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      CLKB,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       clr,
   input  logic [CHANNELS-1:0]       sig,
   input  logic [CHANNELS-1:0]       oneshot,
   input  logic                      load,
   input  logic [CW-1:0]             load_ch,
   input  logic [WIDTH-1:0]          load_val,
   output logic [CHANNELS*WIDTH-1:0] count,
   output logic [CHANNELS-1:0]       full,
   output logic [CHANNELS-1:0]       tc,
   output logic [CHANNELS-1:0]       done
);

   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] DELAY_W = WIDTH'(DELAY);
   localparam logic [WIDTH:0]   K_W     = (WIDTH+1)'(K);

   logic [WIDTH-1:0]    count_q [CHANNELS];
   logic [WIDTH-1:0]    count_d [CHANNELS];
   logic [WIDTH-1:0]    term_q  [CHANNELS];
   logic [WIDTH-1:0]    term_d  [CHANNELS];
   logic [WIDTH:0]      sum_w   [CHANNELS];
   logic [WIDTH-1:0]    sat_w   [CHANNELS];
   logic [CHANNELS-1:0] tc_q, tc_d;
   logic [CHANNELS-1:0] done_q, done_d;
   logic [CHANNELS-1:0] sig_dly_q;
   logic [CHANNELS-1:0] ev;
   logic [CHANNELS-1:0] load_hit;

   always_comb begin
      ev       = en & ((EDGE != 0) ? (sig & ~sig_dly_q) : sig);
      load_hit = '0;
      tc_d     = '0;
      done_d   = done_q;
      for (int i = 0; i < CHANNELS; i++) begin
         // Out-of-range load_ch matches no channel, so the write is dropped.
         load_hit[i] = load && (int'(load_ch) == i);
         count_d[i]  = count_q[i];
         term_d[i]   = term_q[i];
         sum_w[i]    = {1'b0, count_q[i]} + K_W;
         sat_w[i]    = (sum_w[i] > {1'b0, term_q[i]}) ? term_q[i] : sum_w[i][WIDTH-1:0];

         if (load_hit[i]) begin
            term_d[i]  = load_val;
            count_d[i] = '0;
            done_d[i]  = 1'b0;
         end else if (clr[i]) begin
            count_d[i] = '0;
            done_d[i]  = 1'b0;
         end else if (ev[i] && !done_q[i]) begin
            if (count_q[i] < term_q[i]) begin
               count_d[i] = sat_w[i];
               tc_d[i]    = (sat_w[i] == term_q[i]);
            end else if (count_q[i] == term_q[i]) begin
               if (!oneshot[i]) begin
                  count_d[i] = DELAY_W;
                  tc_d[i]    = (DELAY_W == term_q[i]);
               end else begin
                  done_d[i]  = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge CLKB or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            count_q[i] <= '0;
            term_q[i]  <= MAX_W;
         end
         tc_q      <= '0;
         done_q    <= '0;
         sig_dly_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            count_q[i] <= count_d[i];
            term_q[i]  <= term_d[i];
         end
         tc_q      <= tc_d;
         done_q    <= done_d;
         sig_dly_q <= sig;
      end
   end

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_out
         assign count[g*WIDTH +: WIDTH] = count_q[g];
         assign full[g]                 = (count_q[g] == term_q[g]);

         // A count above the terminal only arises from DELAY > term.
         a_no_overshoot : assert property (@(posedge CLKB) disable iff (!rst_n)
            count_q[g] <= term_q[g]);
      end
   endgenerate

   assign tc   = tc_q;
   assign done = done_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Scoreboard bench for event_counter_bank: three instances (defaults, K=3 with
// three channels, rising-edge mode) driven by directed vectors.
module tb_event_counter_bank;

   localparam int K_CNT = 0, K_TC = 1, K_FULL = 2, K_DONE = 3;

   typedef struct {
      int    due;
      int    inst;
      int    kind;
      int    ch;
      int    val;
      string name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   logic CLKB  = 1'b0;
   logic rst_n = 1'b0;

   // instance A: defaults
   logic [3:0]  a_en, a_clr, a_sig, a_one;
   logic        a_load;
   logic [1:0]  a_lch;
   logic [7:0]  a_lval;
   logic [31:0] a_count;
   logic [3:0]  a_full, a_tc, a_done;

   // instance B: three channels, K=3
   logic [2:0]  b_en, b_clr, b_sig, b_one;
   logic        b_load;
   logic [1:0]  b_lch;
   logic [7:0]  b_lval;
   logic [23:0] b_count;
   logic [2:0]  b_full, b_tc, b_done;

   // instance C: rising-edge events
   logic [3:0]  c_en, c_clr, c_sig, c_one;
   logic        c_load;
   logic [1:0]  c_lch;
   logic [7:0]  c_lval;
   logic [31:0] c_count;
   logic [3:0]  c_full, c_tc, c_done;

   always #5 CLKB = ~CLKB;
   always @(posedge CLKB) cyc <= cyc + 1;

   event_counter_bank u_a (
      .CLKB(CLKB), .rst_n(rst_n), .en(a_en), .clr(a_clr), .sig(a_sig),
      .oneshot(a_one), .load(a_load), .load_ch(a_lch), .load_val(a_lval),
      .count(a_count), .full(a_full), .tc(a_tc), .done(a_done));

   event_counter_bank #(.CHANNELS(3), .K(3)) u_b (
      .CLKB(CLKB), .rst_n(rst_n), .en(b_en), .clr(b_clr), .sig(b_sig),
      .oneshot(b_one), .load(b_load), .load_ch(b_lch), .load_val(b_lval),
      .count(b_count), .full(b_full), .tc(b_tc), .done(b_done));

   event_counter_bank #(.EDGE(1)) u_c (
      .CLKB(CLKB), .rst_n(rst_n), .en(c_en), .clr(c_clr), .sig(c_sig),
      .oneshot(c_one), .load(c_load), .load_ch(c_lch), .load_val(c_lval),
      .count(c_count), .full(c_full), .tc(c_tc), .done(c_done));

   function automatic int get(input int inst, input int kind, input int ch);
      logic [31:0] cnt;
      logic [3:0]  tcv, fv, dv;
      case (inst)
         0:       begin cnt = a_count;         tcv = a_tc;         fv = a_full;         dv = a_done;         end
         1:       begin cnt = {8'd0, b_count}; tcv = {1'b0, b_tc}; fv = {1'b0, b_full}; dv = {1'b0, b_done}; end
         default: begin cnt = c_count;         tcv = c_tc;         fv = c_full;         dv = c_done;         end
      endcase
      case (kind)
         K_CNT:   return int'(cnt[ch*8 +: 8]);
         K_TC:    return int'(tcv[ch]);
         K_FULL:  return int'(fv[ch]);
         default: return int'(dv[ch]);
      endcase
   endfunction

   // ofs=1: value expected after the next rising edge; ofs=0: at the next falling edge
   task automatic ex(input int inst, input int kind, input int ch, input int val,
                     input string nm, input int ofs = 1);
      exp_t e;
      e.due = cyc + ofs; e.inst = inst; e.kind = kind; e.ch = ch; e.val = val; e.name = nm;
      q.push_back(e);
   endtask

   task automatic exc(input int inst, input int ch, input int cnt, input int t,
                      input int f, input string nm);
      ex(inst, K_CNT, ch, cnt, nm);
      ex(inst, K_TC, ch, t, nm);
      ex(inst, K_FULL, ch, f, nm);
   endtask

   task automatic tick();
      @(negedge CLKB);
   endtask

   always @(negedge CLKB) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         int   act;
         e   = q.pop_front();
         act = get(e.inst, e.kind, e.ch);
         checks++;
         if (act != e.val) begin
            errors++;
            $display("FAIL %s: inst %0d ch %0d kind %0d got %0d expected %0d (t=%0t)",
                     e.name, e.inst, e.ch, e.kind, act, e.val, $time);
         end
      end
   end

   initial begin
      int wrap_v[6];
      int sat_v[4];
      wrap_v = '{1, 2, 3, 4, 0, 1};
      sat_v  = '{3, 6, 7, 0};
      {a_en, a_clr, a_sig, a_one, a_load, a_lch, a_lval} = '0;
      {b_en, b_clr, b_sig, b_one, b_load, b_lch, b_lval} = '0;
      {c_en, c_clr, c_sig, c_one, c_load, c_lch, c_lval} = '0;
      repeat (2) tick();
      rst_n = 1'b1;

      // reset state
      for (int ch = 0; ch < 4; ch++) begin
         exc(0, ch, 0, 0, 0, "rst_state");
         ex(0, K_DONE, ch, 0, "rst_done");
      end
      exc(1, 0, 0, 0, 0, "rst_b");
      exc(2, 2, 0, 0, 0, "rst_c");
      tick();

      // wrap, level mode, default terminal 4
      a_en[0] = 1'b1; a_sig[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exc(0, 0, wrap_v[i], int'(wrap_v[i] == 4), int'(wrap_v[i] == 4), "wrap");
         ex(0, K_CNT, 1, 0, "wrap_other");
         tick();
      end
      a_en[0] = 1'b0; a_sig[0] = 1'b0;

      // one-shot on channel 1
      a_one[1] = 1'b1; a_en[1] = 1'b1; a_sig[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exc(0, 1, (i < 4) ? i + 1 : 4, int'(i == 3), int'(i >= 3), "oneshot");
         ex(0, K_DONE, 1, int'(i >= 4), "oneshot_done");
         tick();
      end
      a_clr[1] = 1'b1;
      exc(0, 1, 0, 0, 0, "clr_with_ev");
      ex(0, K_DONE, 1, 0, "clr_done");
      tick();
      a_clr[1] = 1'b0; a_en[1] = 1'b0; a_sig[1] = 1'b0;
      exc(0, 1, 0, 0, 0, "clr_hold");
      tick();

      // load on channel 3, with an event the same cycle and channel 0 counting alongside
      a_en[3] = 1'b1; a_sig[3] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exc(0, 3, i + 1, 0, 0, "pre_load");
         tick();
      end
      a_load = 1'b1; a_lch = 2'd3; a_lval = 8'd9;
      a_en[0] = 1'b1; a_sig[0] = 1'b1;
      exc(0, 3, 0, 0, 0, "load_with_ev");
      ex(0, K_CNT, 0, 2, "load_other_ch");
      tick();
      a_load = 1'b0; a_en[0] = 1'b0; a_sig[0] = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exc(0, 3, i + 1, int'(i == 8), int'(i == 8), "term9");
         tick();
      end
      a_en[3] = 1'b0; a_sig[3] = 1'b0;

      // build count0=3 and done1=1, then async reset mid-cycle
      a_en[0] = 1'b1; a_sig[0] = 1'b1; a_en[1] = 1'b1; a_sig[1] = 1'b1;
      ex(0, K_CNT, 0, 3, "pre_rst0");
      ex(0, K_CNT, 1, 1, "pre_rst1");
      tick();
      a_en[0] = 1'b0; a_sig[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ex(0, K_CNT, 1, (i < 2) ? i + 2 : 4, "pre_rst1");
         ex(0, K_DONE, 1, int'(i == 3), "pre_rst_done");
         tick();
      end
      a_en[1] = 1'b0; a_sig[1] = 1'b0;
      @(posedge CLKB);
      #3 rst_n = 1'b0;
      ex(0, K_CNT, 0, 0, "async_cnt0", 0);
      ex(0, K_CNT, 1, 0, "async_cnt1", 0);
      ex(0, K_DONE, 1, 0, "async_done1", 0);
      ex(0, K_TC, 1, 0, "async_tc1", 0);
      ex(0, K_CNT, 3, 0, "async_cnt3", 0);
      ex(0, K_FULL, 3, 0, "async_full3", 0);
      @(negedge CLKB);
      #1 rst_n = 1'b1;
      a_one[1] = 1'b0;
      a_en[0] = 1'b1; a_sig[0] = 1'b1; a_en[3] = 1'b1; a_sig[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exc(0, 0, i + 1, int'(i == 3), int'(i == 3), "post_rst0");
         exc(0, 3, i + 1, int'(i == 3), int'(i == 3), "post_rst_term3");
         tick();
      end
      a_en = '0; a_sig = '0;

      // K=3 saturation against loaded terminal 7
      b_load = 1'b1; b_lch = 2'd0; b_lval = 8'd7;
      exc(1, 0, 0, 0, 0, "b_load");
      tick();
      b_load = 1'b0;
      b_en[0] = 1'b1; b_sig[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exc(1, 0, sat_v[i], int'(sat_v[i] == 7), int'(sat_v[i] == 7), "sat_k3");
         tick();
      end
      b_en[0] = 1'b0; b_sig[0] = 1'b0;

      // out-of-range load_ch on a three-channel bank
      b_en[1] = 1'b1; b_sig[1] = 1'b1;
      exc(1, 1, 3, 0, 0, "b_pre");
      tick();
      b_en[1] = 1'b0;
      b_load = 1'b1; b_lch = 2'd3; b_lval = 8'd1;
      exc(1, 0, 0, 0, 0, "oor_ch0");
      exc(1, 1, 3, 0, 0, "oor_ch1");
      exc(1, 2, 0, 0, 0, "oor_ch2");
      tick();
      b_load = 1'b0;
      b_en[1] = 1'b1;
      exc(1, 1, 4, 1, 1, "oor_term_kept");
      tick();
      b_en = '0; b_sig = '0;

      // rising-edge mode on channel 2
      c_en[2] = 1'b1; c_sig[2] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         exc(2, 2, 1, 0, 0, "edge_held");
         tick();
      end
      c_sig[2] = 1'b0;
      exc(2, 2, 1, 0, 0, "edge_low");
      tick();
      for (int p = 0; p < 3; p++) begin
         c_sig[2] = 1'b1;
         exc(2, 2, p + 2, int'(p == 2), int'(p == 2), "edge_pulse");
         tick();
         c_sig[2] = 1'b0;
         exc(2, 2, p + 2, 0, int'(p == 2), "edge_gap");
         tick();
      end
      c_en[2] = 1'b0; c_sig[2] = 1'b1;
      exc(2, 2, 4, 0, 1, "edge_en_low");
      tick();
      c_en[2] = 1'b1;
      exc(2, 2, 4, 0, 1, "edge_no_new_rise");
      tick();
      c_en = '0; c_sig = '0;

      repeat (3) tick();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
